// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: D = A - B, LSB first,
// one shared 1-bit subtractor cell stepped over WIDTH cycles.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] d_out,
    output logic             b_out,
    output logic             zero_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [WIDTH-1:0] sh_nxt;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             bor_nxt;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;

    // operands shift right, so bit 0 is always bit i = cnt
    assign a_bit   = a_reg[0];
    assign b_bit   = b_reg[0];
    assign d_bit   = a_bit ^ b_bit ^ bor;
    assign bor_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor);
    assign sh_nxt  = {d_bit, sh_reg[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));

    assign busy_out = (state != IDLE);
    assign done_out = (state == DONE);

    // state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and datapath control
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // operand capture, bit stepping and borrow chain
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_reg  <= '0;
            b_reg  <= '0;
            sh_reg <= '0;
            cnt    <= '0;
            bor    <= 1'b0;
        end else if (load) begin
            a_reg  <= a_in;
            b_reg  <= b_in;
            sh_reg <= '0;
            cnt    <= '0;
            bor    <= 1'b0;
        end else if (step) begin
            a_reg  <= {1'b0, a_reg[WIDTH-1:1]};
            b_reg  <= {1'b0, b_reg[WIDTH-1:1]};
            sh_reg <= sh_nxt;
            cnt    <= cnt + CW'(1);
            bor    <= bor_nxt;
        end
    end

    // result registers, updated only when the last bit completes
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            d_out    <= '0;
            b_out    <= 1'b0;
            zero_out <= 1'b1;
        end else if (step && last) begin
            d_out    <= sh_nxt;
            b_out    <= bor_nxt;
            zero_out <= (sh_nxt == '0);
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and exhaustive bench for serial_sub_ctrl,
// two instances (WIDTH=8 and WIDTH=4) with result scoreboards.
module tb_serial_sub_ctrl;

    typedef struct {
        logic [7:0] d;
        logic       b;
        logic       z;
    } exp8_t;

    typedef struct {
        logic [3:0] d;
        logic       b;
        logic       z;
    } exp4_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] d8;
    logic       bo8;
    logic       z8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4;
    logic       done4;
    logic [3:0] d4;
    logic       bo4;
    logic       z4;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    done8_cnt = 0;
    int    done8_cyc = 0;
    int    done4_cnt = 0;
    exp8_t q8[$];
    exp4_t q4[$];

    serial_sub_ctrl #(.WIDTH(8)) u8 (
        .clk_in  (clk),
        .rst_in  (rst),
        .start_in(start8),
        .a_in    (a8),
        .b_in    (b8),
        .busy_out(busy8),
        .done_out(done8),
        .d_out   (d8),
        .b_out   (bo8),
        .zero_out(z8)
    );

    serial_sub_ctrl #(.WIDTH(4)) u4 (
        .clk_in  (clk),
        .rst_in  (rst),
        .start_in(start4),
        .a_in    (a4),
        .b_in    (b4),
        .busy_out(busy4),
        .done_out(done4),
        .d_out   (d4),
        .b_out   (bo4),
        .zero_out(z4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // WIDTH=8 output monitor: pop and compare on each done pulse
    always @(negedge clk) begin
        if (!rst && done8) begin
            if (q8.size() == 0) begin
                chk("u8_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp8_t e;
                e = q8.pop_front();
                chk("u8_d", {24'd0, d8}, {24'd0, e.d});
                chk("u8_borrow", {31'd0, bo8}, {31'd0, e.b});
                chk("u8_zero", {31'd0, z8}, {31'd0, e.z});
            end
            done8_cnt = done8_cnt + 1;
            done8_cyc = cyc;
        end
    end

    // WIDTH=4 output monitor
    always @(negedge clk) begin
        if (!rst && done4) begin
            if (q4.size() == 0) begin
                chk("u4_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp4_t e;
                e = q4.pop_front();
                chk("u4_d", {28'd0, d4}, {28'd0, e.d});
                chk("u4_borrow", {31'd0, bo4}, {31'd0, e.b});
                chk("u4_zero", {31'd0, z4}, {31'd0, e.z});
            end
            done4_cnt = done4_cnt + 1;
        end
    end

    function automatic exp8_t model8(input logic [7:0] a,
                                     input logic [7:0] b);
        exp8_t e;
        logic [8:0] full;
        full = {1'b0, a} - {1'b0, b};
        e.d = full[7:0];
        e.b = (a < b);
        e.z = (full[7:0] == 8'd0);
        return e;
    endfunction

    function automatic exp4_t model4(input logic [3:0] a,
                                     input logic [3:0] b);
        exp4_t e;
        logic [4:0] full;
        full = {1'b0, a} - {1'b0, b};
        e.d = full[3:0];
        e.b = (a < b);
        e.z = (full[3:0] == 4'd0);
        return e;
    endfunction

    // single-cycle start pulse on u8; returns accepting edge number
    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       output int acc);
        @(negedge clk);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        acc = cyc + 1;
        q8.push_back(model8(a, b));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("u8_busy_after_accept", {31'd0, busy8}, 32'd1);
    endtask

    task automatic wait8(input int n);
        int k;
        k = 0;
        while (done8_cnt == n && k < 40) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("u8_done_seen", {31'd0, done8_cnt != n}, 32'd1);
        @(negedge clk);
        #1;
        chk("u8_done_one_cycle", {31'd0, done8}, 32'd0);
    endtask

    initial begin
        int acc;
        int n;
        int prev;
        int bl;
        int k;

        #12;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_d", {24'd0, d8}, 32'd0);
        chk("rst_b", {31'd0, bo8}, 32'd0);
        chk("rst_zero", {31'd0, z8}, 32'd1);
        chk("rst4_zero", {31'd0, z4}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        n = done8_cnt;
        go8(8'd5, 8'd3, acc);
        wait8(n);
        chk("latency", done8_cyc - acc, 32'd8);
        chk("basic_d", {24'd0, d8}, 32'h02);

        n = done8_cnt;
        go8(8'd3, 8'd5, acc);
        wait8(n);
        n = done8_cnt;
        go8(8'h00, 8'h00, acc);
        wait8(n);
        n = done8_cnt;
        go8(8'h00, 8'hFF, acc);
        wait8(n);
        n = done8_cnt;
        go8(8'hFF, 8'h01, acc);
        wait8(n);

        // extra start and operand changes during RUN
        n = done8_cnt;
        go8(8'h20, 8'h11, acc);
        @(negedge clk);
        chk("hold_d_in_run", {24'd0, d8}, 32'hFE);
        start8 = 1'b1;
        a8 = 8'h77;
        b8 = 8'h99;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'h01;
        b8 = 8'h80;
        wait8(n);
        repeat (12) @(negedge clk);
        chk("single_done", done8_cnt - n, 32'd1);

        // start held high: back-to-back every WIDTH+2 cycles
        n = done8_cnt;
        @(negedge clk);
        a8 = 8'd7;
        b8 = 8'd2;
        start8 = 1'b1;
        for (int i = 0; i < 3; i++) q8.push_back(model8(8'd7, 8'd2));
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (done8_cnt == n + i && k < 40) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("held_done_seen", {31'd0, done8_cnt == n + i + 1}, 32'd1);
            if (i > 0) chk("held_interval", done8_cyc - prev, 32'd10);
            prev = done8_cyc;
        end
        start8 = 1'b0;
        repeat (14) @(negedge clk);
        chk("held_count", done8_cnt - n, 32'd3);

        // asynchronous reset at bit 4
        n = done8_cnt;
        go8(8'h40, 8'h03, acc);
        repeat (4) @(posedge clk);
        void'(q8.pop_back());
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
        chk("mid_rst_done", {31'd0, done8}, 32'd0);
        chk("mid_rst_d", {24'd0, d8}, 32'd0);
        chk("mid_rst_zero", {31'd0, z8}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_rst_no_done", done8_cnt - n, 32'd0);
        go8(8'd9, 8'd9, acc);
        wait8(n);
        chk("after_rst_zero", {31'd0, z8}, 32'd1);

        // WIDTH=4 exhaustive sweep with busy-length check
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                @(negedge clk);
                a4 = 4'(a);
                b4 = 4'(b);
                start4 = 1'b1;
                q4.push_back(model4(4'(a), 4'(b)));
                @(posedge clk);
                #1;
                start4 = 1'b0;
                bl = 0;
                k = 0;
                @(negedge clk);
                while (busy4 && k < 20) begin
                    bl++;
                    k++;
                    @(negedge clk);
                end
                chk("u4_busy_len", bl, 32'd5);
            end
        end
        repeat (3) @(negedge clk);
        chk("u4_done_total", done4_cnt, 32'd256);
        chk("u4_queue_empty", q4.size(), 32'd0);
        chk("u8_queue_empty", q8.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
